apb_sram_arbiter: RTL

APB_SRAM_ARBITER -- requirements
Module: apb_sram_arbiter

---
 rtl/apb_sram_arbiter_if.sv | 71 +++++++
 rtl/apb_sram_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/apb_sram_arbiter_if.sv
//------------------------------------------------------------------
// Module   : apb_sram_arbiter_if
// Purpose  : Bundles the two requester command/response channels
//            and the APB master bus of apb_sram_arbiter.
//            master = arbiter side, slave = requesters + APB slave.
// Revision : 1.0 - initial release
//------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef APB_SRAM_SIZE
`define APB_SRAM_SIZE 32'h0000_1000
`endif

interface apb_sram_arbiter_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  // requester 0
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_write;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;
  logic                  rsp0_err;
  // requester 1
  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_write;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;
  logic                  rsp1_err;
  // APB
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

`default_nettype wire

// File: rtl/apb_sram_arbiter.sv
//------------------------------------------------------------------
// Module   : apb_sram_arbiter
// Purpose  : Round-robin arbiter between two requesters driving a
//            single APB master (IDLE/SETUP/ACCESS) with an ACCESS
//            timeout and one-cycle registered response pulses.
// Revision : 1.0 - initial release
//------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module apb_sram_arbiter #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int TIMEOUT    = 8
) (
  input  logic               clk,
  input  logic               rst,
  apb_sram_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // last ACCESS cycle index before the transfer is abandoned
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;      // requester that wins a tie
  logic                  gnt_q, gnt_d;      // requester owning the transfer
  logic [7:0]            cnt_q, cnt_d;      // ACCESS cycles already spent
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp0_err_q, rsp0_err_d;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic                  rsp1_err_q, rsp1_err_d;
  logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic                  any_valid;
  logic                  winner;
  logic                  psel;
  logic                  penable;
  logic                  apb_done;
  logic                  req0_ready;
  logic                  req1_ready;
  logic                  rsp_fire;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  assign any_valid = bus.req0_valid | bus.req1_valid;
  // a lone request always wins; on a tie the pointer decides
  assign winner    = (bus.req0_valid & bus.req1_valid) ? ptr_q : bus.req1_valid;
  assign psel      = (state_q != ST_IDLE);
  assign penable   = (state_q == ST_ACCESS);
  // prdata/pslverr are only meaningful on a completing ACCESS cycle
  assign apb_done  = psel & penable & bus.pready;

  assign bus.psel       = psel;
  assign bus.penable    = penable;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.req0_ready = req0_ready;
  assign bus.req1_ready = req1_ready;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp0_err   = rsp0_err_q;
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp1_err   = rsp1_err_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;

  // next-state, grant, command latch and response steering
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_fire   = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;

    case (state_q)
      ST_IDLE: begin
        // ready is withheld during reset even though the state is IDLE
        if (!rst && any_valid) begin
          req0_ready = ~winner;
          req1_ready = winner;
          gnt_d      = winner;
          ptr_d      = ~winner;
          pwrite_d   = winner ? bus.req1_write : bus.req0_write;
          paddr_d    = winner ? bus.req1_addr  : bus.req0_addr;
          pwdata_d   = winner ? bus.req1_wdata : bus.req0_wdata;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_done) begin
          rsp_fire  = 1'b1;
          rsp_err   = bus.pslverr;
          rsp_rdata = (pwrite_q | bus.pslverr) ? '0 : bus.prdata;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          rsp_fire  = 1'b1;
          rsp_err   = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // only the owner of the transfer sees a pulse; the other stays 0
    rsp0_valid_d = rsp_fire & ~gnt_q;
    rsp0_err_d   = rsp_fire & ~gnt_q & rsp_err;
    rsp0_rdata_d = (rsp_fire & ~gnt_q) ? rsp_rdata : '0;
    rsp1_valid_d = rsp_fire & gnt_q;
    rsp1_err_d   = rsp_fire & gnt_q & rsp_err;
    rsp1_rdata_d = (rsp_fire & gnt_q) ? rsp_rdata : '0;
  end

  // state registers; reset aborts any transfer without a response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      gnt_q        <= 1'b0;
      cnt_q        <= '0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_err_q   <= rsp1_err_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

endmodule

`default_nettype wire
